// File: rtl/gfx256_pkg.sv
// Shared types and helpers for the gfx256 render pipeline.
// Pixel writer FSM states, colour-depth encodings, bytes-per-pixel helper.
package gfx256_pkg;

  typedef enum logic [2:0] {
    PW_IDLE,
    PW_CALC,
    PW_COLOR_WR,
    PW_DEPTH_CALC,
    PW_DEPTH_WR,
    PW_DONE
  } pixel_writer_state_e;

  localparam logic [1:0] CD_8BPP  = 2'b00;
  localparam logic [1:0] CD_16BPP = 2'b01;
  localparam logic [1:0] CD_32BPP = 2'b10;
  localparam logic [1:0] CD_30BPP = 2'b11;

  function automatic logic [2:0] fnBytesPerPixel(
    input logic [1:0] color_depth
  );
    logic [2:0] bpp;
    bpp = 3'd4;
    unique case (1'b1)
      color_depth == CD_8BPP:  bpp = 3'd1;
      color_depth == CD_16BPP: bpp = 3'd2;
      default:                 bpp = 3'd4;
    endcase
    return bpp;
  endfunction

endpackage

// File: rtl/gfx256_pixel_writer_if.sv
// Render write bus between the pixel writer and the wishbone
// writer arbiter: request/ack handshake plus arbiter busy.
interface gfx256_pixel_writer_if;
  logic [31:5]  render_addr;
  logic [31:0]  render_sel;
  logic [255:0] render_dat;
  logic         render_write;
  logic         render_ack;
  logic         wbm_busy;

  modport master (
    output render_addr, render_sel, render_dat, render_write,
    input  render_ack, wbm_busy
  );

  modport slave (
    input  render_addr, render_sel, render_dat, render_write,
    output render_ack, wbm_busy
  );
endinterface

// File: rtl/gfx256_lane_packer.sv
// Places a 1/2/4-byte value at a byte lane of the 256-bit bus
// and builds the matching byte-select mask.
module gfx256_lane_packer (
  input  logic [4:0]   lane_i,
  input  logic [2:0]   nbytes_i,
  input  logic [31:0]  value_i,
  output logic [31:0]  sel_o,
  output logic [255:0] dat_o
);

  logic [31:0] mask;

  always_comb begin
    mask = 32'h0000_00FF;
    unique case (1'b1)
      nbytes_i[2]: mask = 32'hFFFF_FFFF;
      nbytes_i[1]: mask = 32'h0000_FFFF;
      default:     mask = 32'h0000_00FF;
    endcase
    sel_o = ((32'd1 << nbytes_i) - 32'd1) << lane_i;
    dat_o = {224'd0, value_i & mask} << {lane_i, 3'b000};
  end

endmodule

// File: rtl/gfx256_pixel_writer.sv
// Final render stage: writes one pixel's colour (and optional z)
// to the 256-bit memory bus, then acks the blender.
module gfx256_pixel_writer
  import gfx256_pkg::*;
#(
  parameter int point_width = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [31:5]                   target_base_i,
  input  logic [31:5]                   zbuffer_base_i,
  input  logic [point_width-1:0]        target_size_x_i,
  input  logic [1:0]                    color_depth_i,
  input  logic                          zbuffer_enable_i,
  input  logic [point_width-1:0]        pixel_x_i,
  input  logic [point_width-1:0]        pixel_y_i,
  input  logic signed [point_width-1:0] pixel_z_i,
  input  logic [31:0]                   pixel_color_i,
  input  logic                          write_i,
  output logic                          ack_o,
  gfx256_pixel_writer_if.master         bus
);

  localparam int PW2 = 2 * point_width;

  pixel_writer_state_e state;

  logic [point_width-1:0] x_q, y_q;
  logic [15:0]            z_q;
  logic [31:0]            color_q;
  logic [1:0]             cd_q;
  logic                   zen_q;
  logic [PW2-1:0]         prod_q, prod_c, prod_s;

  logic [31:5]  addr_q;
  logic [31:0]  sel_q;
  logic [255:0] dat_q;
  logic         wr_q;

  logic         is_depth;
  logic [2:0]   bpp;
  logic [31:0]  idx, offset, val;
  logic [31:5]  base, addr_c;
  logic [31:0]  sel_c;
  logic [255:0] dat_c;

  assign prod_c = {{point_width{1'b0}}, y_q}
                * {{point_width{1'b0}}, target_size_x_i};

  // CALC issues the colour request on the edge that also
  // registers prod, so it uses the product directly.
  assign prod_s = (state == PW_CALC) ? prod_c : prod_q;
  assign is_depth = (state == PW_DEPTH_CALC)
                 || (state == PW_DEPTH_WR);

  assign idx    = 32'(prod_s) + 32'(x_q);
  assign bpp    = is_depth ? 3'd2 : fnBytesPerPixel(cd_q);
  assign offset = idx << bpp[2:1];
  assign base   = is_depth ? zbuffer_base_i : target_base_i;
  assign addr_c = base + offset[31:5];
  assign val    = is_depth ? {16'd0, z_q} : color_q;

  gfx256_lane_packer u_packer (
    .lane_i   (offset[4:0]),
    .nbytes_i (bpp),
    .value_i  (val),
    .sel_o    (sel_c),
    .dat_o    (dat_c)
  );

  assign bus.render_addr  = addr_q;
  assign bus.render_sel   = sel_q;
  assign bus.render_dat   = dat_q;
  assign bus.render_write = wr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= PW_IDLE;
      ack_o  <= 1'b0;
      wr_q   <= 1'b0;
      addr_q <= '0;
      sel_q  <= 32'hFFFF_FFFF;
      dat_q  <= '0;
    end else begin
      ack_o <= 1'b0;
      unique case (state)
        PW_IDLE: begin
          if (write_i) begin
            x_q     <= pixel_x_i;
            y_q     <= pixel_y_i;
            z_q     <= pixel_z_i[15:0];
            color_q <= pixel_color_i;
            cd_q    <= color_depth_i;
            zen_q   <= zbuffer_enable_i;
            state   <= PW_CALC;
          end
        end
        PW_CALC, PW_DEPTH_CALC: begin
          if (state == PW_CALC) prod_q <= prod_c;
          state <= (state == PW_CALC) ? PW_COLOR_WR : PW_DEPTH_WR;
          if (!bus.wbm_busy) begin
            wr_q   <= 1'b1;
            addr_q <= addr_c;
            sel_q  <= sel_c;
            dat_q  <= dat_c;
          end
        end
        PW_COLOR_WR, PW_DEPTH_WR: begin
          if (!wr_q) begin
            if (!bus.wbm_busy) begin
              wr_q   <= 1'b1;
              addr_q <= addr_c;
              sel_q  <= sel_c;
              dat_q  <= dat_c;
            end
          end else if (bus.render_ack) begin
            wr_q <= 1'b0;
            if (state == PW_COLOR_WR && zen_q) begin
              state <= PW_DEPTH_CALC;
            end else begin
              state <= PW_DONE;
              ack_o <= 1'b1;
            end
          end
        end
        PW_DONE: state <= PW_IDLE;
        default: state <= PW_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gfx256_pixel_writer.sv
// Scoreboard bench for gfx256_pixel_writer: expected bus writes
// are queued at stimulus time and popped when the bench acks.
module tb_gfx256_pixel_writer;

  typedef struct packed {
    logic [26:0]  addr;
    logic [31:0]  sel;
    logic [255:0] dat;
  } wr_t;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic [31:5]  target_base = 27'h100;
  logic [31:5]  zbuffer_base = 27'h200;
  logic [15:0]  width = 16'd640;
  logic [1:0]   cd = 2'b00;
  logic         zen = 1'b0;
  logic [15:0]  px = '0, py = '0;
  logic signed [15:0] pz = '0;
  logic [31:0]  pcol = '0;
  logic         write_i = 1'b0;
  logic         ack_o;

  gfx256_pixel_writer_if bus ();

  gfx256_pixel_writer #(.point_width(16)) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .target_base_i    (target_base),
    .zbuffer_base_i   (zbuffer_base),
    .target_size_x_i  (width),
    .color_depth_i    (cd),
    .zbuffer_enable_i (zen),
    .pixel_x_i        (px),
    .pixel_y_i        (py),
    .pixel_z_i        (pz),
    .pixel_color_i    (pcol),
    .write_i          (write_i),
    .ack_o            (ack_o),
    .bus              (bus)
  );

  always #5 clk = ~clk;

  int  n_chk = 0;
  int  n_fail = 0;
  int  ack_cnt = 0;
  int  exp_acks = 0;
  logic ack_en = 1'b1;
  wr_t sb_q[$];

  task automatic check(input string tag,
                       input logic [255:0] obs,
                       input logic [255:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic wr_t model(input logic [26:0] b,
                                input logic [31:0] i,
                                input int nb,
                                input logic [31:0] v);
    wr_t w;
    logic [31:0] off;
    int lane;
    off = i * nb;
    lane = int'(off[4:0]);
    w.addr = b + off[31:5];
    w.sel = '0;
    w.dat = '0;
    for (int k = 0; k < nb; k++) begin
      w.sel[lane+k] = 1'b1;
      w.dat[8*(lane+k) +: 8] = v[8*k +: 8];
    end
    return w;
  endfunction

  task automatic load(input int x, input int y, input int z,
                      input logic [31:0] c, input logic [1:0] d,
                      input logic ze, input logic push);
    logic [31:0] i;
    int nb;
    px = 16'(x); py = 16'(y); pz = 16'(z);
    pcol = c; cd = d; zen = ze;
    if (push) begin
      i = 32'(y) * 32'(width) + 32'(x);
      nb = (d == 2'b00) ? 1 : (d == 2'b01) ? 2 : 4;
      sb_q.push_back(model(target_base, i, nb, c));
      if (ze)
        sb_q.push_back(model(zbuffer_base, i, 2, {16'd0, 16'(z)}));
      exp_acks++;
    end
  endtask

  task automatic wait_ack(input int exp_lat, input string tag);
    int n;
    logic found;
    n = 0;
    found = 1'b0;
    while (!found && n < 60) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (ack_o) found = 1'b1;
    end
    check({tag, "_seen"}, found, 1'b1);
    if (exp_lat >= 0) check(tag, n, exp_lat);
  endtask

  // Bench-side arbiter: acks every request the same cycle it appears.
  always @(negedge clk) begin
    if (rst_i || !ack_en) begin
      bus.render_ack = 1'b0;
    end else if (bus.render_write && !bus.render_ack) begin
      check("sb_pending", sb_q.size() != 0, 1'b1);
      if (sb_q.size() != 0) begin
        wr_t w;
        w = sb_q.pop_front();
        check("wr_addr", bus.render_addr, w.addr);
        check("wr_sel", bus.render_sel, w.sel);
        check("wr_dat", bus.render_dat, w.dat);
      end
      bus.render_ack = 1'b1;
    end else begin
      bus.render_ack = 1'b0;
    end
  end

  always @(negedge clk) if (ack_o) ack_cnt++;

  initial begin
    int acks0;
    int t;
    logic [26:0] a;
    bus.wbm_busy = 1'b0;
    bus.render_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_write", bus.render_write, 1'b0);
    check("rst_ack", ack_o, 1'b0);
    check("rst_addr", bus.render_addr, 27'd0);
    check("rst_sel", bus.render_sel, 32'hFFFF_FFFF);
    check("rst_dat", bus.render_dat, 256'd0);
    rst_i = 1'b0;

    // 32bpp: offset 0xA0C -> addr 0x150, lane 12
    @(negedge clk);
    load(3, 1, 0, 32'h00A1_B2C3, 2'b10, 1'b0, 1'b0);
    sb_q.push_back('{27'h150, 32'h0000_F000, 256'h00A1B2C3 << 96});
    exp_acks++;
    write_i = 1'b1;
    wait_ack(3, "lat_32bpp");
    write_i = 1'b0;

    // 8bpp top lane
    width = 16'd64;
    @(negedge clk);
    load(31, 0, 0, 32'h0000_005A, 2'b00, 1'b0, 1'b0);
    sb_q.push_back('{27'h100, 32'h8000_0000, 256'h5A << 248});
    exp_acks++;
    write_i = 1'b1;
    wait_ack(3, "lat_8bpp");
    write_i = 1'b0;

    // 16bpp with depth: colour then z at lane 2
    width = 16'd16;
    target_base = 27'h300;
    @(negedge clk);
    load(17, 1, -2, 32'h0000_BEEF, 2'b01, 1'b1, 1'b0);
    sb_q.push_back('{27'h302, 32'h0000_000C, 256'hBEEF << 16});
    sb_q.push_back('{27'h202, 32'h0000_000C, 256'hFFFE << 16});
    exp_acks++;
    write_i = 1'b1;
    wait_ack(5, "lat_z");
    write_i = 1'b0;

    // busy held off the request for 5 cycles
    width = 16'd640;
    @(negedge clk);
    bus.wbm_busy = 1'b1;
    load(100, 7, 0, 32'h3FF0_0C01, 2'b11, 1'b0, 1'b1);
    write_i = 1'b1;
    fork
      wait_ack(8, "lat_busy");
      begin
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("busy_hold", bus.render_write, 1'b0);
        bus.wbm_busy = 1'b0;
      end
    join
    write_i = 1'b0;

    // busy raised after request: request stays up
    @(negedge clk);
    ack_en = 1'b0;
    load(5, 3, 0, 32'hCAFE_F00D, 2'b10, 1'b0, 1'b1);
    write_i = 1'b1;
    fork
      wait_ack(-1, "ack_sticky");
      begin
        t = 0;
        while (!bus.render_write && t < 20) begin
          @(negedge clk);
          t++;
        end
        check("req_seen", bus.render_write, 1'b1);
        a = bus.render_addr;
        bus.wbm_busy = 1'b1;
        repeat (3) @(negedge clk);
        check("wr_sticky", bus.render_write, 1'b1);
        check("addr_stable", bus.render_addr, a);
        bus.wbm_busy = 1'b0;
        ack_en = 1'b1;
      end
    join
    write_i = 1'b0;

    // reset while waiting for ack: pixel lost, no ack_o
    @(negedge clk);
    ack_en = 1'b0;
    load(9, 9, 0, 32'h1111_2222, 2'b10, 1'b0, 1'b0);
    write_i = 1'b1;
    t = 0;
    while (!bus.render_write && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("rst_req_seen", bus.render_write, 1'b1);
    acks0 = ack_cnt;
    rst_i = 1'b1;
    write_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;
    check("mid_rst_write", bus.render_write, 1'b0);
    check("mid_rst_sel", bus.render_sel, 32'hFFFF_FFFF);
    check("mid_rst_addr", bus.render_addr, 27'd0);
    check("mid_rst_dat", bus.render_dat, 256'd0);
    ack_en = 1'b1;
    repeat (6) @(negedge clk);
    check("mid_rst_noack", ack_cnt, acks0);
    load(2, 0, 0, 32'h0000_7788, 2'b01, 1'b0, 1'b1);
    write_i = 1'b1;
    wait_ack(3, "lat_after_rst");
    write_i = 1'b0;

    // back-to-back with write_i held through ack_o
    @(negedge clk);
    acks0 = ack_cnt;
    load(10, 2, 0, 32'hAABB_CCDD, 2'b10, 1'b0, 1'b1);
    write_i = 1'b1;
    wait_ack(3, "b2b_first");
    load(11, 2, 0, 32'h0102_0304, 2'b10, 1'b0, 1'b1);
    wait_ack(4, "b2b_second");
    write_i = 1'b0;
    repeat (8) @(negedge clk);
    check("b2b_pulses", ack_cnt - acks0, 2);

    // a few random pixels
    for (int r = 0; r < 8; r++) begin
      logic ze;
      width = 16'($urandom_range(1, 1000));
      ze = 1'($urandom_range(0, 1));
      @(negedge clk);
      load($urandom_range(0, 999), $urandom_range(0, 500),
           $urandom_range(0, 65535), $urandom,
           2'($urandom_range(0, 3)), ze, 1'b1);
      write_i = 1'b1;
      wait_ack(ze ? 5 : 3, "lat_rand");
      write_i = 1'b0;
    end

    repeat (4) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);
    check("ack_total", ack_cnt, exp_acks);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
